imem_loader: RTL
================

# imem_loader

Load controller and port arbiter for the word-addressed instruction memory. It shares the memory's single address port between the CPU fetch path and a byte-serial program loader fed by the board's UART/debug front end. During a load it holds the CPU, feeds it NOPs, assembles four bytes per instruction word and writes consecutive words from address 0. When no load is active it passes CPU fetch addresses and instruction data straight through.

## Interface
- ADDR_W, 10: word-address width of the instruction memory.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- load_len  in  ADDR_W+1  number of words to load; captured on the accepted load_start.
- byte_in  in  8  loader data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  controller accepts byte_in this cycle.
- cpu_addr  in  ADDR_W  CPU fetch word address (PC>>2).
- cpu_inst  out  32  instruction delivered to the CPU.
- cpu_hold  out  1  CPU must stall and not advance its PC.
- mem_addr  out  ADDR_W  instruction memory address.
- mem_wdata  out  32  instruction memory write data.
- mem_we  out  1  instruction memory write enable; the memory writes synchronously on this edge.
- mem_rdata  in  32  instruction memory read data (combinational read).
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when a load completes.
- chksum  out  32  checksum of the last load (see Configuration).

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - mem_addr=cpu_addr, cpu_inst=mem_rdata, cpu_hold=0, byte_ready=0, mem_we=0.
  - load_start=1 captures load_len, clamped to 2**ADDR_W. It clears the word pointer, byte counter and checksum.
  - If the clamped len is 0 go to DONE; otherwise go to RECV.
- RECV:
  - byte_ready=1.
  - Each byte_valid&&byte_ready handshake stores byte_in little-endian: byte 0 goes to [7:0], byte 3 to [31:24].
  - The 4th byte goes to WRITE.
- WRITE, exactly one cycle:
  - mem_we=1, mem_addr=word pointer, mem_wdata=assembled word, byte_ready=0.
  - The word pointer increments and the checksum updates.
  - If words written equals len go to DONE; otherwise go to RECV.
- DONE, one cycle: done=1, then IDLE.
- In all non-IDLE states: cpu_hold=1, busy=1, cpu_inst=32'h00000013 (addi x0,x0,0).
  - mem_addr=word pointer, so the CPU never drives the memory during a load.
- load_start outside IDLE is ignored.
- byte_valid outside RECV is ignored; no handshake occurs.
- The word pointer is ADDR_W bits. A len of exactly 2**ADDR_W ends after address 2**ADDR_W-1, with no wrap write to 0.

## Timing
- Reset values: state=IDLE, busy=0, cpu_hold=0, byte_ready=0, mem_we=0, done=0, mem_wdata=0, chksum=0, word pointer=0, byte counter=0.
  - mem_addr/cpu_inst follow the IDLE pass-through.
- Reset mid-load aborts immediately and returns to IDLE. Words already written stay in memory. Partial bytes are discarded.
- Per word: 4 accepted bytes, then 1 WRITE cycle. Minimum 5 cycles/word with byte_valid held high.
- Load latency with a continuous byte stream: load_start edge to done = 5·len+1 cycles (len=0: done on the cycle after start).
- cpu_hold rises in the cycle after the accepted load_start and falls in the cycle after DONE.
- The pass-through path is purely combinational, so fetch latency is unchanged from a direct memory connection.

## Configuration
- IMEM_LOADER_CHKSUM_EN defined:
  - chksum = running 32-bit sum, mod 2**32, of every word written in the current load.
  - Updated in WRITE, cleared on an accepted load_start, held after DONE.
- Not defined: chksum is tied to 32'h0 and no adder is synthesized.

## Test plan
- Reset, idle, cpu_addr=5, memory word 5=32'h00100073 -> cpu_inst=32'h00100073, cpu_hold=0, mem_we never asserted.
- load_len=2, bytes 13,00,10,00,93,00,20,00 with continuous valid:
  - mem writes 32'h00100013@0 and 32'h00200093@1.
  - done exactly 11 cycles after start.
  - chksum=32'h003000A6 with macro, 0 without.
- Same load with byte_valid toggling every other cycle -> identical memory contents, only accepted handshakes counted, cpu_inst=32'h00000013 throughout.
- load_len=0 -> no mem_we, done pulse on the next cycle. A second load_start asserted during busy is ignored.
- rst_n low after 6 bytes of a 2-word load -> word 0 written, word 1 untouched, all outputs at reset values, then a fresh load succeeds.
- load_len=2**ADDR_W+5 -> clamped: exactly 1024 writes, last at address 1023, no write to 0 after wrap.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: shares the instruction memory port between CPU fetch and a byte-serial program loader.
// Latency: combinational fetch pass-through when idle; a load takes 5 cycles/word plus 1 (start to done).
// Backpressure: byte_ready is high only while collecting bytes; the CPU is held with NOPs during a load.
// Optional checksum of the loaded words is built when IMEM_LOADER_CHKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [31:0]       cpu_inst,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       chksum
);

  localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [31:0]     NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t          state;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] wcnt;      // words written; low bits are the write pointer
  logic [1:0]      bcnt;
  logic [23:0]     asm_q;     // first three bytes of the word being assembled

  logic [ADDR_W:0] len_clamped;
  logic            start_acc;
  logic            byte_hs;

  assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign start_acc   = (state == IDLE) && load_start;
  assign byte_hs     = byte_valid && byte_ready;

  // While loading, the memory port belongs to the loader and the CPU sees NOPs.
  assign mem_addr = busy ? wcnt[ADDR_W-1:0] : cpu_addr;
  assign cpu_inst = busy ? NOP_INST : mem_rdata;

  // Load sequencing FSM with registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      wcnt       <= '0;
      bcnt       <= '0;
      asm_q      <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            len_q    <= len_clamped;
            wcnt     <= '0;
            bcnt     <= '0;
            asm_q    <= '0;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            if (len_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= RECV;
              byte_ready <= 1'b1;
            end
          end
        end
        RECV: begin
          if (byte_hs) begin
            case (bcnt)
              2'd0: asm_q[7:0]   <= byte_in;
              2'd1: asm_q[15:8]  <= byte_in;
              2'd2: asm_q[23:16] <= byte_in;
              default: begin
                mem_wdata  <= {byte_in, asm_q};
                mem_we     <= 1'b1;
                byte_ready <= 1'b0;
                state      <= WRITE;
              end
            endcase
            bcnt <= bcnt + 2'd1;
          end
        end
        WRITE: begin
          mem_we <= 1'b0;
          wcnt   <= wcnt + ONE_WORD;
          if (wcnt + ONE_WORD == len_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end
        default: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [31:0] sum_q;

  // Running sum of words written in the current load; held after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (start_acc) begin
      sum_q <= '0;
    end else if (state == WRITE) begin
      sum_q <= sum_q + mem_wdata;
    end
  end

  assign chksum = sum_q;
`else
  assign chksum = 32'h0;
`endif

endmodule
